// File: rtl/pc_fetch_ctrl.sv
// Fetch-PC generator for the IF stage: req/gnt handshake, stall handling,
// trap/branch redirects, and buffering of redirects that arrive while the PC cannot advance.
module pc_fetch_ctrl #(
  parameter int unsigned          ADDR_W     = 32,
  parameter int unsigned          INST_BYTES = 4,
  parameter logic [ADDR_W-1:0]    RESET_VEC  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0]    TRAP_VEC   = 32'h0000_0100
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [5:0]        i_stall,
  input  logic              i_branch_valid,
  input  logic [ADDR_W-1:0] i_branch_addr,
  input  logic              i_trap_valid,
  input  logic              i_if_gnt,
  output logic [ADDR_W-1:0] o_pc_addr,
  output logic              o_ce,
  output logic              o_if_req,
  output logic              o_redir_pend,
  output logic              o_misalign_err
);

  localparam int unsigned ALIGN_BITS = $clog2(INST_BYTES);

  logic              r_ce;
  logic [ADDR_W-1:0] r_pc;
  logic              r_pend_valid;
  logic              r_pend_trap;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_misalign;

  logic              w_adv;
  logic [ADDR_W-1:0] w_branch_aligned;
  logic              w_branch_low_nz;
  logic              w_branch_accept;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_unused_stall;

  // Only the IF-stage bit of the stall vector matters here.
  assign w_unused_stall   = ^i_stall[5:1];

  assign w_adv            = r_ce & ~i_stall[0] & i_if_gnt;
  assign w_branch_aligned = {i_branch_addr[ADDR_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
  assign w_branch_low_nz  = |i_branch_addr[ALIGN_BITS-1:0];

  // A branch counts as accepted if it is taken now or lands in the pending buffer.
  assign w_branch_accept  = r_ce & i_branch_valid & ~i_trap_valid &
                            (w_adv | ~(r_pend_valid & r_pend_trap));

  always_comb begin
    w_pc_next = r_pc + ADDR_W'(INST_BYTES);
    if (i_trap_valid) begin
      w_pc_next = TRAP_VEC;
    end else if (i_branch_valid) begin
      w_pc_next = w_branch_aligned;
    end else if (r_pend_valid) begin
      w_pc_next = r_pend_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ce         <= 1'b0;
      r_pc         <= RESET_VEC;
      r_pend_valid <= 1'b0;
      r_pend_trap  <= 1'b0;
      r_pend_addr  <= '0;
      r_misalign   <= 1'b0;
    end else begin
      r_ce       <= 1'b1;
      r_misalign <= w_branch_accept & w_branch_low_nz;
      if (w_adv) begin
        // Any redirect taken on this edge supersedes whatever was buffered.
        r_pc         <= w_pc_next;
        r_pend_valid <= 1'b0;
        r_pend_trap  <= 1'b0;
      end else if (r_ce) begin
        if (i_trap_valid) begin
          r_pend_valid <= 1'b1;
          r_pend_trap  <= 1'b1;
          r_pend_addr  <= TRAP_VEC;
        end else if (i_branch_valid && !(r_pend_valid && r_pend_trap)) begin
          r_pend_valid <= 1'b1;
          r_pend_trap  <= 1'b0;
          r_pend_addr  <= w_branch_aligned;
        end
      end
    end
  end

  assign o_pc_addr      = r_pc;
  assign o_ce           = r_ce;
  assign o_if_req       = r_ce & ~i_stall[0];
  assign o_redir_pend   = r_pend_valid;
  assign o_misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl; each task drives one scenario and checks inline.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  stall;
  logic        branch_valid;
  logic [31:0] branch_addr;
  logic        trap_valid;
  logic        if_gnt;
  logic [31:0] pc_addr;
  logic        ce;
  logic        if_req;
  logic        redir_pend;
  logic        misalign_err;

  int cmp_cnt;
  int err_cnt;

  pc_fetch_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_stall        (stall),
    .i_branch_valid (branch_valid),
    .i_branch_addr  (branch_addr),
    .i_trap_valid   (trap_valid),
    .i_if_gnt       (if_gnt),
    .o_pc_addr      (pc_addr),
    .o_ce           (ce),
    .o_if_req       (if_req),
    .o_redir_pend   (redir_pend),
    .o_misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = '0; branch_valid = 1'b0; branch_addr = '0;
    trap_valid = 1'b0; if_gnt = 1'b1;
    tick(); tick();
    cmp_cnt++; if (ce !== 1'b0) begin err_cnt++; $display("FAIL rst_ce got %b want 0", ce); end
    cmp_cnt++; if (pc_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_pc got %h want 0", pc_addr); end
    cmp_cnt++; if (redir_pend !== 1'b0) begin err_cnt++; $display("FAIL rst_pend got %b want 0", redir_pend); end
    cmp_cnt++; if (misalign_err !== 1'b0) begin err_cnt++; $display("FAIL rst_mis got %b want 0", misalign_err); end
    cmp_cnt++; if (if_req !== 1'b0) begin err_cnt++; $display("FAIL rst_req got %b want 0", if_req); end
    rst_n = 1'b1;
    tick();
    cmp_cnt++; if (ce !== 1'b1) begin err_cnt++; $display("FAIL edge1_ce got %b want 1", ce); end
    cmp_cnt++; if (pc_addr !== 32'h0) begin err_cnt++; $display("FAIL edge1_pc got %h want 0", pc_addr); end
    cmp_cnt++; if (if_req !== 1'b1) begin err_cnt++; $display("FAIL edge1_req got %b want 1", if_req); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      cmp_cnt++;
      if (pc_addr !== 32'(i * 4)) begin
        err_cnt++; $display("FAIL seq_pc%0d got %h want %h", i, pc_addr, 32'(i * 4));
      end
    end
    $display("test_reset done pc=%h", pc_addr);
  endtask

  task automatic test_branch();
    repeat (5) tick();
    cmp_cnt++; if (pc_addr !== 32'h20) begin err_cnt++; $display("FAIL pre_br_pc got %h want 20", pc_addr); end
    branch_valid = 1'b1; branch_addr = 32'h80;
    tick();
    cmp_cnt++; if (pc_addr !== 32'h80) begin err_cnt++; $display("FAIL br_pc got %h want 80", pc_addr); end
    cmp_cnt++; if (misalign_err !== 1'b0) begin err_cnt++; $display("FAIL br_mis got %b want 0", misalign_err); end
    branch_addr = 32'h83;
    tick();
    branch_valid = 1'b0;
    cmp_cnt++; if (pc_addr !== 32'h80) begin err_cnt++; $display("FAIL br_mis_pc got %h want 80", pc_addr); end
    cmp_cnt++; if (misalign_err !== 1'b1) begin err_cnt++; $display("FAIL br_mis_pulse got %b want 1", misalign_err); end
    tick();
    cmp_cnt++; if (misalign_err !== 1'b0) begin err_cnt++; $display("FAIL br_mis_end got %b want 0", misalign_err); end
    cmp_cnt++; if (pc_addr !== 32'h84) begin err_cnt++; $display("FAIL br_after_pc got %h want 84", pc_addr); end
    $display("test_branch done pc=%h", pc_addr);
  endtask

  task automatic test_stall_buffer();
    stall = 6'b000001; branch_valid = 1'b1; branch_addr = 32'h200;
    tick();
    branch_valid = 1'b0;
    cmp_cnt++; if (if_req !== 1'b0) begin err_cnt++; $display("FAIL st_req got %b want 0", if_req); end
    cmp_cnt++; if (pc_addr !== 32'h84) begin err_cnt++; $display("FAIL st_pc got %h want 84", pc_addr); end
    cmp_cnt++; if (redir_pend !== 1'b1) begin err_cnt++; $display("FAIL st_pend got %b want 1", redir_pend); end
    tick(); tick();
    cmp_cnt++; if (pc_addr !== 32'h84) begin err_cnt++; $display("FAIL st_hold_pc got %h want 84", pc_addr); end
    cmp_cnt++; if (redir_pend !== 1'b1) begin err_cnt++; $display("FAIL st_hold_pend got %b want 1", redir_pend); end
    stall = '0;
    tick();
    cmp_cnt++; if (pc_addr !== 32'h200) begin err_cnt++; $display("FAIL st_rel_pc got %h want 200", pc_addr); end
    cmp_cnt++; if (redir_pend !== 1'b0) begin err_cnt++; $display("FAIL st_rel_pend got %b want 0", redir_pend); end
    stall = 6'b111110;
    tick();
    stall = '0;
    cmp_cnt++; if (pc_addr !== 32'h204) begin err_cnt++; $display("FAIL upper_stall_pc got %h want 204", pc_addr); end
    $display("test_stall_buffer done pc=%h", pc_addr);
  endtask

  task automatic test_trap_priority();
    stall = 6'b000001; branch_valid = 1'b1; branch_addr = 32'h300;
    tick();
    branch_valid = 1'b0; trap_valid = 1'b1;
    tick();
    trap_valid = 1'b0; branch_valid = 1'b1; branch_addr = 32'h400;
    tick();
    branch_valid = 1'b0; stall = '0;
    cmp_cnt++; if (redir_pend !== 1'b1) begin err_cnt++; $display("FAIL tr_pend got %b want 1", redir_pend); end
    tick();
    cmp_cnt++; if (pc_addr !== 32'h100) begin err_cnt++; $display("FAIL tr_rel_pc got %h want 100", pc_addr); end
    cmp_cnt++; if (redir_pend !== 1'b0) begin err_cnt++; $display("FAIL tr_rel_pend got %b want 0", redir_pend); end
    trap_valid = 1'b1; branch_valid = 1'b1; branch_addr = 32'h503;
    tick();
    trap_valid = 1'b0; branch_valid = 1'b0;
    cmp_cnt++; if (pc_addr !== 32'h100) begin err_cnt++; $display("FAIL trbr_pc got %h want 100", pc_addr); end
    cmp_cnt++; if (misalign_err !== 1'b0) begin err_cnt++; $display("FAIL trbr_mis got %b want 0", misalign_err); end
    tick();
    cmp_cnt++; if (pc_addr !== 32'h104) begin err_cnt++; $display("FAIL trbr_next got %h want 104", pc_addr); end
    stall = 6'b000001; branch_valid = 1'b1; branch_addr = 32'h600;
    tick();
    branch_addr = 32'h702;
    tick();
    branch_valid = 1'b0;
    cmp_cnt++; if (misalign_err !== 1'b1) begin err_cnt++; $display("FAIL buf_mis got %b want 1", misalign_err); end
    tick();
    stall = '0;
    cmp_cnt++; if (misalign_err !== 1'b0) begin err_cnt++; $display("FAIL buf_mis_end got %b want 0", misalign_err); end
    tick();
    cmp_cnt++; if (pc_addr !== 32'h700) begin err_cnt++; $display("FAIL buf_new_pc got %h want 700", pc_addr); end
    $display("test_trap_priority done pc=%h", pc_addr);
  endtask

  task automatic test_gnt_wait();
    branch_valid = 1'b1; branch_addr = 32'h40;
    tick();
    branch_valid = 1'b0; if_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp_cnt++; if (if_req !== 1'b1) begin err_cnt++; $display("FAIL gnt_req%0d got %b want 1", i, if_req); end
      cmp_cnt++; if (pc_addr !== 32'h40) begin err_cnt++; $display("FAIL gnt_pc%0d got %h want 40", i, pc_addr); end
    end
    if_gnt = 1'b1;
    tick();
    cmp_cnt++; if (pc_addr !== 32'h44) begin err_cnt++; $display("FAIL gnt_rel_pc got %h want 44", pc_addr); end
    branch_valid = 1'b1; branch_addr = 32'hFFFF_FFFC;
    tick();
    branch_valid = 1'b0;
    cmp_cnt++; if (pc_addr !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL wrap_pre got %h want fffffffc", pc_addr); end
    tick();
    cmp_cnt++; if (pc_addr !== 32'h0) begin err_cnt++; $display("FAIL wrap_pc got %h want 0", pc_addr); end
    $display("test_gnt_wait done pc=%h", pc_addr);
  endtask

  task automatic test_reset_mid();
    repeat (3) tick();
    stall = 6'b000001; branch_valid = 1'b1; branch_addr = 32'h900;
    tick();
    branch_valid = 1'b0;
    cmp_cnt++; if (redir_pend !== 1'b1) begin err_cnt++; $display("FAIL mid_pend_pre got %b want 1", redir_pend); end
    #2 rst_n = 1'b0;
    #1;
    cmp_cnt++; if (pc_addr !== 32'h0) begin err_cnt++; $display("FAIL mid_pc got %h want 0", pc_addr); end
    cmp_cnt++; if (redir_pend !== 1'b0) begin err_cnt++; $display("FAIL mid_pend got %b want 0", redir_pend); end
    cmp_cnt++; if (ce !== 1'b0) begin err_cnt++; $display("FAIL mid_ce got %b want 0", ce); end
    stall = '0;
    tick();
    rst_n = 1'b1;
    tick();
    cmp_cnt++; if (ce !== 1'b1 || pc_addr !== 32'h0) begin err_cnt++; $display("FAIL mid_rel got ce=%b pc=%h want ce=1 pc=0", ce, pc_addr); end
    tick();
    cmp_cnt++; if (pc_addr !== 32'h4) begin err_cnt++; $display("FAIL mid_restart got %h want 4", pc_addr); end
    cmp_cnt++; if (redir_pend !== 1'b0) begin err_cnt++; $display("FAIL mid_restart_pend got %b want 0", redir_pend); end
    $display("test_reset_mid done pc=%h", pc_addr);
  endtask

  initial begin
    cmp_cnt = 0;
    err_cnt = 0;
    rst_n = 1'b0;
    stall = '0; branch_valid = 1'b0; branch_addr = '0; trap_valid = 1'b0; if_gnt = 1'b1;
    test_reset();
    test_branch();
    test_stall_buffer();
    test_trap_priority();
    test_gnt_wait();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
